// File: rtl/mdc_fft_sequencer.sv
// Control-plane sequencer for a radix-2 MDC FFT chain: handshake, pipe enable,
// commutator selects, twiddle indices, flush and output tagging.
module mdc_fft_sequencer #(
    parameter int N_POINTS = 16,
    parameter int BF_LAT   = 1,
    localparam int S       = $clog2(N_POINTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 pipe_en,
    output logic                 in_sel_zero,
    output logic [S-2:0]         switch_sel,
    output logic [S*(S-1)-1:0]   tw_idx,
    output logic                 out_valid,
    output logic                 out_first,
    output logic                 busy
);

    localparam int M  = N_POINTS / 2;
    localparam int L  = S * BF_LAT + M - 1;
    localparam int PW = S - 1;
    localparam int GW = $clog2(M) + $clog2(L + 1);
    localparam int FW = $clog2(L + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [L-1:0]    tag_q, tag_d;
    logic [FW-1:0]   fl_q, fl_d;
    logic [S-2:0]    sw_raw;
    logic [S*PW-1:0] tw_raw;
    logic            idle;

    function automatic int dsum(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += M >> (j + 1);
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        fl_d        = fl_q;
        in_ready    = 1'b1;
        pipe_en     = 1'b0;
        in_sel_zero = 1'b0;
        unique case (state_q)
            IDLE: begin
                pipe_en = in_valid;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                pipe_en = in_valid;
                // Only leave at a frame boundary; mid-frame gaps just stall.
                if (!in_valid && g_q[PW-1:0] == '0) begin
                    state_d = FLUSH;
                    fl_d    = '0;
                end
            end
            FLUSH: begin
                in_ready    = 1'b0;
                pipe_en     = 1'b1;
                in_sel_zero = 1'b1;
                if (fl_q == FW'(L - 1)) state_d = IDLE;
                else fl_d = fl_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        g_d   = pipe_en ? g_q + 1'b1 : g_q;
        if (state_d == IDLE) g_d = '0;
        tag_d = pipe_en ? {tag_q[L-2:0], in_valid & in_ready} : tag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            tag_q   <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            tag_q   <= tag_d;
            fl_q    <= fl_d;
        end
    end

    for (genvar k = 0; k < S - 1; k++) begin : g_sw
        localparam int OFF = (k + 1) * BF_LAT + dsum(k);
        logic [PW-1:0] p;
        assign p         = g_q[PW-1:0] - PW'(OFF);
        assign sw_raw[k] = |(p & PW'(1 << (S - 2 - k)));
    end

    for (genvar k = 0; k < S; k++) begin : g_tw
        localparam int TOFF = k * BF_LAT + dsum(k);
        logic [PW-1:0] t;
        assign t = g_q[PW-1:0] - PW'(TOFF);
        assign tw_raw[k*PW +: PW] = PW'((t & PW'((M >> k) - 1)) << k);
    end

    assign idle       = (state_q == IDLE);
    assign busy       = !idle;
    assign switch_sel = idle ? '0 : sw_raw;
    assign tw_idx     = idle ? '0 : tw_raw;
    assign out_valid  = !idle && tag_q[L-1];
    assign out_first  = out_valid && ((g_q[PW-1:0] - PW'(L)) == '0);

endmodule

// File: tb/tb_mdc_fft_sequencer.sv
// Directed bench for mdc_fft_sequencer at N_POINTS=16, BF_LAT=1 (M=8, L=11).
module tb_mdc_fft_sequencer;

    logic        clk, reset, in_valid;
    logic        in_ready, pipe_en, in_sel_zero;
    logic [2:0]  switch_sel;
    logic [11:0] tw_idx;
    logic        out_valid, out_first, busy;

    int checks = 0;
    int errors = 0;

    mdc_fft_sequencer #(.N_POINTS(16), .BF_LAT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_ready(in_ready), .pipe_en(pipe_en),
        .in_sel_zero(in_sel_zero), .switch_sel(switch_sel),
        .tw_idx(tw_idx), .out_valid(out_valid),
        .out_first(out_first), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic iv, rdy, pe, z, bsy, ov, of;
    } vec_t;

    vec_t tbl [0:20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        in_valid = v;
        #1;
    endtask

    initial begin
        int b, nov;
        logic [2:0] tw1 [0:4];
        tw1[0] = 3'd0; tw1[1] = 3'd2; tw1[2] = 3'd4;
        tw1[3] = 3'd6; tw1[4] = 3'd0;

        for (int c = 0; c < 21; c++) begin
            tbl[c].iv  = (c < 8);
            tbl[c].rdy = !(c >= 9 && c <= 19);
            tbl[c].pe  = (c < 8) || (c >= 9 && c <= 19);
            tbl[c].z   = (c >= 9 && c <= 19);
            tbl[c].bsy = (c >= 1 && c <= 19);
            tbl[c].ov  = (c >= 12 && c <= 19);
            tbl[c].of  = (c == 12);
        end

        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pe", pipe_en, 0);
        chk("rst_zero", in_sel_zero, 0);
        chk("rst_sw", switch_sel, 0);
        chk("rst_tw", tw_idx, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_of", out_first, 0);
        @(negedge clk);
        reset = 1'b0;

        // single frame, table driven
        for (int c = 0; c < 21; c++) begin
            drive(tbl[c].iv);
            chk($sformatf("t1_rdy_c%0d", c), in_ready, tbl[c].rdy);
            chk($sformatf("t1_pe_c%0d", c), pipe_en, tbl[c].pe);
            chk($sformatf("t1_zero_c%0d", c), in_sel_zero, tbl[c].z);
            chk($sformatf("t1_busy_c%0d", c), busy, tbl[c].bsy);
            chk($sformatf("t1_ov_c%0d", c), out_valid, tbl[c].ov);
            chk($sformatf("t1_of_c%0d", c), out_first, tbl[c].of);
        end

        // commutator selects and twiddles over one frame
        for (int c = 0; c < 21; c++) begin
            drive(c < 8);
            b = (c < 8) ? c : (c == 8 ? -1 : c - 1);
            if (b >= 1 && b <= 4) chk($sformatf("sw0_b%0d", b), switch_sel[0], 0);
            if (b >= 5 && b <= 8) chk($sformatf("sw0_b%0d", b), switch_sel[0], 1);
            if (b == 8 || b == 9) chk($sformatf("sw1_b%0d", b), switch_sel[1], 1);
            if (b >= 9 && b <= 18)
                chk($sformatf("sw2_b%0d", b), switch_sel[2], (b - 9) & 1);
            if (b >= 5 && b <= 9)
                chk($sformatf("tw1_b%0d", b), tw_idx[5:3], tw1[b-5]);
        end

        // two frames back to back
        nov = 0;
        for (int c = 0; c < 29; c++) begin
            drive(c < 16);
            b = (c < 16) ? c : (c == 16 ? -1 : (c <= 27 ? c - 1 : -2));
            if (b >= 0) begin
                chk($sformatf("b2b_zero_b%0d", b), in_sel_zero, b >= 16);
                chk($sformatf("b2b_ov_b%0d", b), out_valid, b >= 11 && b <= 26);
                chk($sformatf("b2b_of_b%0d", b), out_first, b == 11 || b == 19);
                if (out_valid) nov++;
            end
            if (b == -1) begin
                chk("b2b_stall_pe", pipe_en, 0);
                chk("b2b_stall_ov", out_valid, 1);
            end
            if (b == -2) chk("b2b_idle", busy, 0);
        end
        chk("b2b_ov_count", nov, 16);

        // stall of 3 cycles after beat 3
        for (int c = 0; c < 24; c++) begin
            drive((c < 4) || (c >= 7 && c <= 10));
            if (c == 3) chk("stl_sw_b3", switch_sel, 3'b000);
            if (c >= 4 && c <= 6) begin
                chk($sformatf("stl_pe_c%0d", c), pipe_en, 0);
                chk($sformatf("stl_sw_c%0d", c), switch_sel, 3'b110);
                chk($sformatf("stl_tw_c%0d", c), tw_idx, 12'd52);
                chk($sformatf("stl_rdy_c%0d", c), in_ready, 1);
                chk($sformatf("stl_ov_c%0d", c), out_valid, 0);
            end
            if (c == 14) chk("stl_ov_early", out_valid, 0);
            if (c == 15) begin
                chk("stl_ov_first", out_valid, 1);
                chk("stl_of_first", out_first, 1);
            end
            if (c == 22) chk("stl_ov_last", out_valid, 1);
            if (c == 23) chk("stl_idle", busy, 0);
        end

        // reset in the 5th flush cycle
        for (int c = 0; c < 14; c++) drive(c < 8);
        chk("rf_in_flush", in_sel_zero, 1);
        chk("rf_ov_before", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("rf_ov", out_valid, 0);
        chk("rf_busy", busy, 0);
        chk("rf_rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            drive(c < 8);
            if (c == 0) begin
                chk("rf2_busy0", busy, 0);
                chk("rf2_pe0", pipe_en, 1);
            end
            if (c == 1) begin
                chk("rf2_sw_b1", switch_sel, 3'b010);
                chk("rf2_tw_b1", tw_idx, 12'd257);
            end
            if (c == 11) chk("rf2_ov_b10", out_valid, 0);
            if (c == 12) begin
                chk("rf2_ov_b11", out_valid, 1);
                chk("rf2_of_b11", out_first, 1);
            end
            if (c == 20) chk("rf2_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdc_fft_sequencer.md
# mdc_fft_sequencer

Sequencer for the radix-2 MDC (multi-path delay commutator) FFT pipeline. It owns the control plane of the chain BF0, COM0, BF1, COM1, …, COM(S-2), BF(S-1), where each COMk is a `delay_commutator` and each BF a butterfly stage. It accepts sample pairs (x0, x1) through a valid/ready handshake and drives one pipeline enable for the whole chain. It also drives the per-commutator switch selects and per-butterfly twiddle indices, drains the pipeline with zero bubbles between frames, and tags valid and first-of-frame outputs.

## Interface
Parameters:
- N_POINTS, 16, FFT size; power of 2, ≥ 8.
- BF_LAT, 1, butterfly latency in pipe_en beats.
- Derived, not overridable:
  - S = log2(N_POINTS).
  - M = N_POINTS/2, the pairs per frame.
  - D_k = M >> (k+1), the delay of COMk.
  - OFF_k = (k+1)·BF_LAT + Σ_{j<k} D_j.
  - TOFF_k = k·BF_LAT + Σ_{j<k} D_j.
  - L = S·BF_LAT + M − 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  the upstream sample pair is valid.
- in_ready  out  1  the sequencer accepts a pair this cycle.
- pipe_en  out  1  advances every stage register and delay line in the chain.
- in_sel_zero  out  1  the datapath injects zeros at x0/x1 (flush bubble).
- switch_sel  out  S-1  bit k is the cross state of COMk.
- tw_idx  out  S·(S-1)  field k (bits k·(S-1) +: S-1) is the twiddle exponent for BFk.
- out_valid  out  1  the chain output pair on this beat is real data.
- out_first  out  1  the output pair is index 0 of a frame.
- busy  out  1  state ≠ IDLE.

## Operation
- State machine with three states: IDLE, RUN, FLUSH.
  - IDLE: in_ready=1. On in_valid, accept the pair; pipe_en=1; go to RUN.
  - RUN: in_ready=1; pipe_en=in_valid.
    - A gap mid-frame (in_valid=0) stalls the chain; g, the tags and all outputs hold.
    - At a frame boundary (g mod M == 0) with in_valid=0, go to FLUSH.
    - With in_valid=1 at the boundary, stay in RUN (back-to-back frames, no bubble).
  - FLUSH: in_ready=0, pipe_en=1, in_sel_zero=1 for exactly L cycles, then go to IDLE.
- g is the global beat counter, width ≥ log2(M)+ceil(log2(L+1)).
  - It increments on every pipe_en beat.
  - It clears to 0 in IDLE.
- Local phases, each mod 2^(S-1):
  - p_k = (g − OFF_k) mod M.
  - t_k = (g − TOFF_k) mod M.
- switch_sel[k] = bit (S-2-k) of p_k, so COMk toggles every D_k beats.
- tw_idx field k = (t_k mod (M>>k)) << k.
- Tag shift register, L deep:
  - It shifts on pipe_en.
  - It inserts 1 for accepted pairs and 0 for bubbles.
  - out_valid = tail tag.
  - out_first = out_valid & ((g − L) mod M == 0).
- In IDLE, switch_sel, tw_idx, out_valid and out_first are forced to 0.

## Timing
- Reset values: state=IDLE, g=0, all tags 0, in_ready=1, busy=0, in_sel_zero=0, switch_sel=0, tw_idx=0, out_valid=0, out_first=0. pipe_en=0 unless in_valid.
- Combinational outputs: in_ready, pipe_en, in_sel_zero. All others are decoded from registered state.
- Latency is L pipe_en beats from acceptance to output. Stall cycles add to this latency.
- FLUSH length is fixed at L and is not interruptible by in_valid.
- Reset asserted mid-operation (any state):
  - The state goes immediately to IDLE.
  - The tags clear; in-flight data is discarded.
  - in_ready reads 1 while reset is held.

## Test plan
All scenarios use N_POINTS=16, BF_LAT=1. This gives M=8, S=4, D=4,2,1, OFF=1,6,9, TOFF=0,5,8,10, L=11. "Beat" means pipe_en beat, with the first accept as beat 0.
- Single frame, in_valid held for 8 cycles:
  - in_ready stays 1 through beat 7.
  - Beats 8–18 are FLUSH with in_sel_zero=1 and in_ready=0.
  - out_valid is 1 on beats 11–18, with out_first on beat 11.
  - busy=0 from beat 19.
- Commutator select, continuous frame:
  - switch_sel[0] is 0 on beats 1–4 and 1 on beats 5–8.
  - switch_sel[1] is 1 on beats 8–9.
  - switch_sel[2] toggles every beat from beat 9.
- Twiddle indices: tw_idx field 1 is 0, 2, 4, 6, 0 on beats 5, 6, 7, 8, 9.
- Two frames back-to-back, 16 continuous beats:
  - There is no FLUSH between the frames.
  - out_valid is 1 for 16 consecutive beats.
  - out_first is 1 on beats 11 and 19.
- Stall: in_valid drops for 3 cycles after beat 3.
  - pipe_en=0 and g holds during the gap; all outputs are unchanged.
  - The first out_valid moves 3 cycles later.
- Reset mid-FLUSH, at the 5th flush cycle:
  - Immediately out_valid=0, busy=0 and in_ready=1.
  - A following frame restarts at g=0, with its first output 11 beats after its own acceptance.
